// File: rtl/ranger_pkg.sv
// ranger_pkg: shared types and timing constants for the ultrasonic ranger.
// Holds the FSM state enum, default derived timing constants and a width helper.
package ranger_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        DONE      = 3'd4
    } state_e;

    localparam int DEF_CLK_HZ    = 100_000_000;
    localparam int DEF_PERIOD_MS = 60;

    localparam int TICK_DIV   = DEF_CLK_HZ / 1_000_000;
    localparam int PERIOD_US  = DEF_PERIOD_MS * 1000;
    localparam int TIMEOUT_US = 30_000;

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ultrasonic_ranger_if.sv
// ultrasonic_ranger_if: sensor pins plus distance sample bundle.
// master = ranger (echo in; trigger, dist_cm, dist_valid, timeout, busy out).
interface ultrasonic_ranger_if #(
    parameter int DIST_W = 9
);
    logic              echo;
    logic              trigger;
    logic [DIST_W-1:0] dist_cm;
    logic              dist_valid;
    logic              timeout;
    logic              busy;

    modport master (
        input  echo,
        output trigger, dist_cm, dist_valid, timeout, busy
    );

    modport slave (
        output echo,
        input  trigger, dist_cm, dist_valid, timeout, busy
    );
endinterface

// File: rtl/echo_sync.sv
// echo_sync: 2-flop synchronizer for an async input plus rise/fall pulses.
// Ports: clk, rst_n (async active-low), async_in in; rise, fall one-cycle out.
module echo_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise,
    output logic fall
);
    // [0],[1] synchronize; [2] is the previous synchronized value.
    logic [2:0] sh_q;
    logic [2:0] sh_d;

    assign sh_d = {sh_q[1:0], async_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign rise = sh_q[1] & ~sh_q[2];
    assign fall = ~sh_q[1] & sh_q[2];
endmodule

// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger: HC-SR04 front end - periodic trigger, echo timing, cm output.
// Ports: clk, rst_n (async active-low), bus (master: echo in; trigger, dist_cm,
//   dist_valid, timeout, busy out). Define RANGER_AVG_EN for 4-sample averaging.
module ultrasonic_ranger #(
    parameter int CLK_HZ     = ranger_pkg::DEF_CLK_HZ,
    parameter int TRIG_US    = 10,
    parameter int PERIOD_MS  = ranger_pkg::DEF_PERIOD_MS,
    parameter int TIMEOUT_US = ranger_pkg::TIMEOUT_US,
    parameter int US_PER_CM  = 58,
    parameter int DIST_W     = 9
) (
    input logic                 clk,
    input logic                 rst_n,
    ultrasonic_ranger_if.master bus
);
    import ranger_pkg::state_e;
    import ranger_pkg::IDLE;
    import ranger_pkg::TRIG;
    import ranger_pkg::WAIT_RISE;
    import ranger_pkg::MEASURE;
    import ranger_pkg::DONE;
    import ranger_pkg::cnt_w;

    localparam int TICK_N = CLK_HZ / 1_000_000;
    localparam int PER_N  = PERIOD_MS * 1000;
    localparam int PH_MAX = (TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US;
    localparam int TICK_W = cnt_w(TICK_N - 1);
    localparam int PER_W  = cnt_w(PER_N);
    localparam int PH_W   = cnt_w(PH_MAX);
    localparam int CM_W   = cnt_w(US_PER_CM);

    state_e state_q, state_d;

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [PER_W-1:0]  per_cnt_q, per_cnt_d;
    logic [PH_W-1:0]   ph_cnt_q, ph_cnt_d;
    logic [CM_W-1:0]   cm_cnt_q, cm_cnt_d;
    logic [DIST_W-1:0] acc_q, acc_d;
    logic [DIST_W-1:0] dist_q, dist_d;
    logic              valid_q, valid_d;
    logic              to_q, to_d;

    logic echo_rise, echo_fall;
    logic tick, per_hit, trig_end, ph_to, cm_wrap, abort;
    logic trigger, busy;

    echo_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (bus.echo),
        .rise     (echo_rise),
        .fall     (echo_fall)
    );

    assign tick     = (tick_cnt_q == TICK_W'(TICK_N - 1));
    assign per_hit  = tick && (per_cnt_q >= PER_W'(PER_N - 1));
    assign trig_end = tick && (ph_cnt_q == PH_W'(TRIG_US - 1));
    assign ph_to    = tick && (ph_cnt_q == PH_W'(TIMEOUT_US - 1));
    assign cm_wrap  = tick && (cm_cnt_q == CM_W'(US_PER_CM - 1));

    // An edge seen on the same tick as the limit wins over the timeout.
    assign abort = ph_to
                && ((state_q == WAIT_RISE && !echo_rise)
                 || (state_q == MEASURE && !echo_fall));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (per_hit) state_d = TRIG;
            TRIG:      if (trig_end) state_d = WAIT_RISE;
            WAIT_RISE: begin
                if (echo_rise) state_d = MEASURE;
                else if (ph_to) state_d = IDLE;
            end
            MEASURE:   begin
                if (echo_fall) state_d = DONE;
                else if (ph_to) state_d = IDLE;
            end
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        trigger = (state_q == TRIG);
        busy    = (state_q != IDLE);
    end

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

        // Period restarts on trigger entry and free-runs through the
        // measurement so the cycle length never depends on the echo.
        per_cnt_d = per_cnt_q;
        if (state_q == IDLE && per_hit) per_cnt_d = '0;
        else if (tick && per_cnt_q != '1) per_cnt_d = per_cnt_q + 1'b1;

        ph_cnt_d = ph_cnt_q;
        if (state_d != state_q || state_q == IDLE) ph_cnt_d = '0;
        else if (tick) ph_cnt_d = ph_cnt_q + 1'b1;

        cm_cnt_d = '0;
        acc_d    = '0;
        if (state_q == MEASURE) begin
            cm_cnt_d = cm_cnt_q;
            acc_d    = acc_q;
            if (cm_wrap) begin
                cm_cnt_d = '0;
                if (acc_q != '1) acc_d = acc_q + 1'b1;
            end else if (tick) begin
                cm_cnt_d = cm_cnt_q + 1'b1;
            end
        end else if (state_q == DONE) begin
            acc_d = acc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            per_cnt_q  <= '0;
            ph_cnt_q   <= '0;
            cm_cnt_q   <= '0;
            acc_q      <= '0;
            dist_q     <= '0;
            valid_q    <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            per_cnt_q  <= per_cnt_d;
            ph_cnt_q   <= ph_cnt_d;
            cm_cnt_q   <= cm_cnt_d;
            acc_q      <= acc_d;
            dist_q     <= dist_d;
            valid_q    <= valid_d;
            to_q       <= to_d;
        end
    end

`ifdef RANGER_AVG_EN
    logic [3:0][DIST_W-1:0] win_q, win_d;
    logic                   fill_q, fill_d;
    logic                   load_q, load_d;
    logic [DIST_W+1:0]      win_sum;

    // The first sample is copied into every slot, so a partly filled
    // window averages against the value that started it.
    always_comb begin
        win_d  = win_q;
        fill_d = fill_q;
        load_d = 1'b0;
        if (state_q == DONE) begin
            if (!fill_q) win_d = {4{acc_q}};
            else win_d = {win_q[2:0], acc_q};
            fill_d = 1'b1;
            load_d = 1'b1;
        end
        win_sum = '0;
        for (int i = 0; i < 4; i++) begin
            win_sum = win_sum + {2'b00, win_q[i]};
        end
        dist_d  = load_q ? win_sum[DIST_W+1:2] : dist_q;
        valid_d = load_q;
        to_d    = abort;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q  <= '0;
            fill_q <= 1'b0;
            load_q <= 1'b0;
        end else begin
            win_q  <= win_d;
            fill_q <= fill_d;
            load_q <= load_d;
        end
    end
`else
    always_comb begin
        dist_d  = (state_q == DONE) ? acc_q : dist_q;
        valid_d = (state_q == DONE);
        to_d    = abort;
    end
`endif

    assign bus.trigger    = trigger;
    assign bus.busy       = busy;
    assign bus.dist_cm    = dist_q;
    assign bus.dist_valid = valid_q;
    assign bus.timeout    = to_q;
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb_ultrasonic_ranger: directed bench for ultrasonic_ranger with scaled timing.
// 2 MHz clock (2 cycles/us), 2 ms period, 1500 us timeout; optional RANGER_AVG_EN.
module tb_ultrasonic_ranger;

    localparam int TRIG_CYC = 20;
    localparam int PER_CYC  = 4000;
    localparam int TO_CYC   = 3000;
    localparam int DLY_CYC  = 400;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_valid = 0;
    int n_to = 0;
    int n_both = 0;

    int w6[4] = '{1160, 1160, 2320, 2320};
`ifdef RANGER_AVG_EN
    int e6[4] = '{10, 10, 12, 15};
`else
    int e6[4] = '{10, 10, 20, 20};
`endif

    always #5 clk = ~clk;

    ultrasonic_ranger_if #(.DIST_W(9)) bus ();

    ultrasonic_ranger #(
        .CLK_HZ     (2_000_000),
        .TRIG_US    (10),
        .PERIOD_MS  (2),
        .TIMEOUT_US (1500),
        .US_PER_CM  (58),
        .DIST_W     (9)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(negedge clk) begin
        if (bus.dist_valid === 1'b1) n_valid++;
        if (bus.timeout === 1'b1) n_to++;
        if (bus.dist_valid === 1'b1 && bus.timeout === 1'b1) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    function automatic logic cond(input int sel);
        case (sel)
            0: return bus.trigger === 1'b1;
            1: return bus.trigger === 1'b0;
            2: return bus.timeout === 1'b1;
            3: return bus.dist_valid === 1'b1;
            default: return 1'b1;
        endcase
    endfunction

    task automatic run_until(input int sel, input int budget, output int n);
        n = 0;
        while (!cond(sel) && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic echo_pulse(input int delay_cyc, input int width_cyc);
        repeat (delay_cyc) step();
        bus.echo = 1'b1;
        repeat (width_cyc) step();
        bus.echo = 1'b0;
    endtask

    task automatic measure(input string tag, input int width_cyc,
                           input int exp_cm);
        int n;
        run_until(1, 100, n);
        echo_pulse(DLY_CYC, width_cyc);
        run_until(3, 100, n);
        chk({tag, "_valid"}, bus.dist_valid, 1);
        chk({tag, "_dist"}, bus.dist_cm, exp_cm);
    endtask

    initial begin
        int n;
        int t_rise;
        int v0;
        int t0;

        bus.echo = 1'b0;
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_trigger", bus.trigger, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_dist", bus.dist_cm, 0);
        chk("rst_valid", bus.dist_valid, 0);
        chk("rst_timeout", bus.timeout, 0);
        rst_n = 1'b1;
        cyc = 0;

        // No echo: trigger timing and wait-for-rise timeout.
        run_until(0, 5000, n);
        chk("t1_first_trig", n, PER_CYC);
        t_rise = cyc;
        chk("t1_busy", bus.busy, 1);
        run_until(1, 100, n);
        chk("t1_trig_width", n, TRIG_CYC);
        run_until(2, 4000, n);
        chk("t1_timeout_delay", n, TO_CYC);
        chk("t1_busy_drop", bus.busy, 0);
        chk("t1_dist", bus.dist_cm, 0);
        step();
        chk("t1_timeout_one_cycle", bus.timeout, 0);
        run_until(0, 5000, n);
        chk("t1_period", cyc - t_rise, PER_CYC);
        t_rise = cyc;
        chk("t1_no_valid", n_valid, 0);

        // Truncation: 579 us -> 9 cm, then 1160 us -> 20 cm.
        measure("t3a", 1158, 9);
        run_until(0, 5000, n);
        chk("t3a_period", cyc - t_rise, PER_CYC);
        t_rise = cyc;
        measure("t3b", 2320, 20);
        run_until(0, 5000, n);
        t_rise = cyc;

        // 580 us -> 10 cm, busy low with the strobe.
        measure("t2", 1160, 10);
        chk("t2_busy", bus.busy, 0);
        chk("t2_no_timeout", bus.timeout, 0);
        step();
        chk("t2_valid_one_cycle", bus.dist_valid, 0);
        run_until(0, 5000, n);
        chk("t2_period", cyc - t_rise, PER_CYC);
        t_rise = cyc;

        // Echo stuck high: width timeout keeps the old distance.
        run_until(1, 100, n);
        repeat (DLY_CYC) step();
        v0 = n_valid;
        bus.echo = 1'b1;
        run_until(2, 4000, n);
        chk("t4_timeout", bus.timeout, 1);
        chk("t4_dist_kept", bus.dist_cm, 10);
        chk("t4_no_valid_now", bus.dist_valid, 0);
        bus.echo = 1'b0;
        run_until(0, 5000, n);
        chk("t4_period", cyc - t_rise, PER_CYC);
        chk("t4_no_valid", n_valid, v0);

        // Reset in the middle of a measurement.
        run_until(1, 100, n);
        repeat (DLY_CYC) step();
        bus.echo = 1'b1;
        repeat (300) step();
        chk("t5_busy_before", bus.busy, 1);
        v0 = n_valid;
        t0 = n_to;
        rst_n = 1'b0;
        #1;
        chk("t5_async_trigger", bus.trigger, 0);
        chk("t5_async_busy", bus.busy, 0);
        chk("t5_async_dist", bus.dist_cm, 0);
        bus.echo = 1'b0;
        repeat (3) step();
        chk("t5_no_valid", n_valid, v0);
        chk("t5_no_timeout", n_to, t0);
        rst_n = 1'b1;
        cyc = 0;
        run_until(0, 5000, n);
        chk("t5_fresh_trig", n, PER_CYC);

        // Sequence 580, 580, 1160, 1160 us (raw or averaged).
        for (int i = 0; i < 4; i++) begin
            if (i > 0) run_until(0, 5000, n);
            measure($sformatf("t6_%0d", i), w6[i], e6[i]);
        end

        step();
        chk("never_both_strobes", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
